ex_memory_request_queue: RTL and testbench
==========================================

# ex_memory_request_queue

Parametrised execute-stage memory request queue that sits between the EX stage address/data path and the data memory port. It turns each load/store request into a lane-aligned memory transaction with byte strobes and shifted write data, including left and right partial accesses. It generalises data width to 32 or 64 bits and buffers up to DEPTH requests behind a valid/ready memory handshake. It also detects misaligned accesses and supports a pipeline flush.

## Interface
- DATA_WIDTH, 32, memory data width; 32 or 64 only. STRB = DATA_WIDTH/8, OFF = log2(STRB).
- DEPTH, 4, queue entries; power of two, ≥ 2.
- ADDRESS_WIDTH, 32, byte address width.

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- request_valid  in  1  EX offers a request
- request_ready  out  1  queue can accept
- request_write  in  1  1 = store, 0 = load
- request_size  in  2  log2 bytes: 0 byte, 1 half, 2 word, 3 dword (legal only when DATA_WIDTH = 64)
- request_mode  in  2  00 normal, 01 left, 10 right, 11 reserved (treated as normal)
- request_address  in  ADDRESS_WIDTH  byte address
- request_data  in  DATA_WIDTH  store data, least-significant aligned
- flush  in  1  exception/eret flush
- memory_valid  out  1  head entry presented
- memory_ready  in  1  memory accepts head
- memory_write  out  1  head is a store
- memory_address  out  ADDRESS_WIDTH  address with low OFF bits zeroed
- memory_write_strobe  out  STRB  byte enables (also valid for loads)
- memory_write_data  out  DATA_WIDTH  lane-positioned store data
- occupancy  out  log2(DEPTH)+1  entries held
- address_error  out  1  one-cycle pulse on a misaligned request
- address_error_address  out  ADDRESS_WIDTH  address of the last misaligned request

## Operation
- Accept when request_valid && request_ready. request_ready = (occupancy < DEPTH). It does not depend on memory_ready.
- Misaligned means mode normal && (address & ((1<<size)-1)) != 0, or size 3 with DATA_WIDTH 32.
  - The request is accepted (handshake completes) but not enqueued.
  - address_error pulses on the next cycle.
  - address_error_address is loaded with the offending address and held until the next error.
- Let off = address[OFF-1:0].
- Strobe generation:
  - normal: (2^(2^size) − 1) << off
  - left: bits 0..off set
  - right: bits off..STRB−1 set
- Write data generation:
  - normal: the low 2^size bytes replicated across all lanes
  - right: data << 8·off
  - left: data >> 8·(STRB−1−off)
- Strobe and data are computed at enqueue and stored per entry together with the aligned address and the write flag.
- The queue is a circular FIFO with read pointer, write pointer and count. Pointers wrap modulo DEPTH.
- memory_valid = (occupancy != 0). The head fields drive the memory outputs.
- Dequeue on memory_valid && memory_ready.
- A simultaneous enqueue and dequeue keeps occupancy unchanged. It is possible only when not full, since ready is low when full.
- flush:
  - On the flush edge, all entries are cleared, pointers reset to 0 and occupancy goes to 0.
  - A head handshake completing in the flush cycle counts as accepted by memory.
  - A request offered in the flush cycle is dropped, even if request_ready is high.
  - address_error is suppressed in that cycle.
- Reset (async, reset_n low): occupancy 0, pointers 0, memory_valid 0, address_error 0, address_error_address 0. Entry payload registers need not be reset. The memory_* outputs other than memory_valid are don't-care while memory_valid is 0.

## Timing
- Enqueue-to-memory latency is 1 cycle: a request accepted in cycle N appears on memory_valid in cycle N+1 at the earliest. There is no combinational bypass.
- Throughput is one request per cycle while memory_ready stays high.
- The head holds stable while memory_valid && !memory_ready.
- address_error asserts for exactly one cycle, in N+1.
- occupancy is registered and updates on the edge after each handshake.
- When reset_n deasserts mid-operation, all in-flight entries are lost. The first acceptance can occur in the first cycle after deassertion.

## Test plan
- Normal stores, DATA_WIDTH 32:
  - SB to 0x1003 with data 0x000000AB -> strobe 1000, data 0xABABABAB, address 0x1000.
  - SH to 0x1002 -> strobe 1100.
- Left/right, DATA_WIDTH 32, data 0x11223344, address offset 1:
  - left -> strobe 0011, data 0x00001122.
  - right -> strobe 1110, data 0x22334400.
- 64-bit SD to 0x2008 -> strobe 0xFF. SW to 0x2004 -> strobe 0xF0, data replicated across the upper lane.
- Fill to full with DEPTH 4 and memory_ready 0:
  - request_ready drops after the 4th accept; occupancy = 4.
  - Release memory_ready -> entries drain in FIFO order, one per cycle.
  - Pointer wrap is correct over 10 requests.
- Misaligned SW to 0x1001 -> handshake completes, nothing enqueued, address_error high for 1 cycle, address_error_address = 0x1001.
- Flush while 3 entries are queued and the head handshake completes in the same cycle -> occupancy 0 next cycle, memory_valid 0, the concurrent request is dropped. Also assert reset_n mid-burst -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/ex_memory_request_queue.sv
// Execute-stage memory request queue: lane-aligns load/store requests (byte strobes and
// shifted write data, including left/right partial accesses) and buffers them for the memory port.
module ex_memory_request_queue #(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        request_valid,
    output logic                        request_ready,
    input  logic                        request_write,
    input  logic [1:0]                  request_size,
    input  logic [1:0]                  request_mode,
    input  logic [ADDRESS_WIDTH-1:0]    request_address,
    input  logic [DATA_WIDTH-1:0]       request_data,
    input  logic                        flush,
    output logic                        memory_valid,
    input  logic                        memory_ready,
    output logic                        memory_write,
    output logic [ADDRESS_WIDTH-1:0]    memory_address,
    output logic [DATA_WIDTH/8-1:0]     memory_write_strobe,
    output logic [DATA_WIDTH-1:0]       memory_write_data,
    output logic [$clog2(DEPTH):0]      occupancy,
    output logic                        address_error,
    output logic [ADDRESS_WIDTH-1:0]    address_error_address
);

    localparam int STRB = DATA_WIDTH / 8;
    localparam int OFF  = $clog2(STRB);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;

    localparam logic [1:0] MODE_LEFT  = 2'b01;
    localparam logic [1:0] MODE_RIGHT = 2'b10;

    logic [OFF-1:0]           off;
    logic                     mode_normal;
    logic                     low_bits_set;
    logic                     misaligned;
    logic                     accept;
    logic                     enqueue;
    logic                     dequeue;
    logic [STRB-1:0]          base_strb;
    logic [STRB-1:0]          right_strb;
    logic [STRB-1:0]          left_strb;
    logic [STRB-1:0]          new_strb;
    logic [DATA_WIDTH-1:0]    rep_data;
    logic [DATA_WIDTH-1:0]    new_data;
    logic [ADDRESS_WIDTH-1:0] new_address;

    logic [PW-1:0]            rd_ptr;
    logic [PW-1:0]            wr_ptr;
    logic [CW-1:0]            count;

    logic                     entry_write   [DEPTH];
    logic [ADDRESS_WIDTH-1:0] entry_address [DEPTH];
    logic [STRB-1:0]          entry_strb    [DEPTH];
    logic [DATA_WIDTH-1:0]    entry_data    [DEPTH];

    assign off         = request_address[OFF-1:0];
    assign mode_normal = (request_mode != MODE_LEFT) && (request_mode != MODE_RIGHT);

    always_comb begin
        low_bits_set = 1'b0;
        base_strb    = '1;
        rep_data     = request_data;
        case (request_size)
            2'd0: begin
                low_bits_set = 1'b0;
                base_strb    = {{(STRB-1){1'b0}}, 1'b1};
                rep_data     = {STRB{request_data[7:0]}};
            end
            2'd1: begin
                low_bits_set = request_address[0];
                base_strb    = {{(STRB-2){1'b0}}, 2'b11};
                rep_data     = {(STRB/2){request_data[15:0]}};
            end
            2'd2: begin
                low_bits_set = |request_address[1:0];
                base_strb    = {{(STRB-4){1'b0}}, 4'hF};
                rep_data     = {(STRB/4){request_data[31:0]}};
            end
            default: begin
                low_bits_set = |request_address[2:0];
                base_strb    = '1;
                rep_data     = request_data;
            end
        endcase
    end

    // A dword request can never be served by a 32-bit port, whatever the mode.
    assign misaligned = (mode_normal && low_bits_set) ||
                        ((request_size == 2'd3) && (DATA_WIDTH == 32));

    // Right covers lanes off..top; left covers lanes 0..off, i.e. the complement of right shifted by one.
    assign right_strb = {STRB{1'b1}} << off;
    assign left_strb  = ~{right_strb[STRB-2:0], 1'b0};

    // STRB is a power of two, so STRB-1-off is just the bitwise inverse of off.
    always_comb begin
        new_strb = base_strb << off;
        new_data = rep_data;
        if (request_mode == MODE_LEFT) begin
            new_strb = left_strb;
            new_data = request_data >> {~off, 3'b000};
        end else if (request_mode == MODE_RIGHT) begin
            new_strb = right_strb;
            new_data = request_data << {off, 3'b000};
        end
    end

    assign new_address = {request_address[ADDRESS_WIDTH-1:OFF], {OFF{1'b0}}};

    assign request_ready = (count < CW'(DEPTH));
    assign accept        = request_valid && request_ready && !flush;
    assign enqueue       = accept && !misaligned;
    assign memory_valid  = (count != '0);
    assign dequeue       = memory_valid && memory_ready;
    assign occupancy     = count;

    assign memory_write        = entry_write[rd_ptr];
    assign memory_address      = entry_address[rd_ptr];
    assign memory_write_strobe = entry_strb[rd_ptr];
    assign memory_write_data   = entry_data[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr                <= '0;
            wr_ptr                <= '0;
            count                 <= '0;
            address_error         <= 1'b0;
            address_error_address <= '0;
        end else if (flush) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            address_error <= 1'b0;
        end else begin
            address_error <= accept && misaligned;
            if (accept && misaligned) begin
                address_error_address <= request_address;
            end
            if (enqueue) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (dequeue) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({enqueue, dequeue})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; validity is tracked entirely by the pointers and count.
    always_ff @(posedge clock) begin
        if (enqueue) begin
            entry_write[wr_ptr]   <= request_write;
            entry_address[wr_ptr] <= new_address;
            entry_strb[wr_ptr]    <= new_strb;
            entry_data[wr_ptr]    <= new_data;
        end
    end

endmodule

// File: tb/tb_ex_memory_request_queue.sv
// Directed bench for ex_memory_request_queue: a 32-bit instance for the vector table and
// queue sequences, plus a 64-bit instance for the wide-lane cases.
module tb_ex_memory_request_queue;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        wr;
    logic [1:0]  size;
    logic [1:0]  mode;
    logic [31:0] addr;
    logic [63:0] data64;
    logic        flush;
    logic        mready;

    logic        v32, rdy32, mv32, mw32, ae32;
    logic [31:0] ma32, md32, aea32;
    logic [3:0]  ms32;
    logic [2:0]  occ32;

    logic        v64, rdy64, mv64, mw64, ae64;
    logic [31:0] ma64, aea64;
    logic [63:0] md64;
    logic [7:0]  ms64;
    logic [2:0]  occ64;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    ex_memory_request_queue #(.DATA_WIDTH(32), .DEPTH(4), .ADDRESS_WIDTH(32)) dut32 (
        .clock(clock), .reset_n(reset_n),
        .request_valid(v32), .request_ready(rdy32), .request_write(wr),
        .request_size(size), .request_mode(mode), .request_address(addr),
        .request_data(data64[31:0]), .flush(flush),
        .memory_valid(mv32), .memory_ready(mready), .memory_write(mw32),
        .memory_address(ma32), .memory_write_strobe(ms32), .memory_write_data(md32),
        .occupancy(occ32), .address_error(ae32), .address_error_address(aea32)
    );

    ex_memory_request_queue #(.DATA_WIDTH(64), .DEPTH(4), .ADDRESS_WIDTH(32)) dut64 (
        .clock(clock), .reset_n(reset_n),
        .request_valid(v64), .request_ready(rdy64), .request_write(wr),
        .request_size(size), .request_mode(mode), .request_address(addr),
        .request_data(data64), .flush(flush),
        .memory_valid(mv64), .memory_ready(mready), .memory_write(mw64),
        .memory_address(ma64), .memory_write_strobe(ms64), .memory_write_data(md64),
        .occupancy(occ64), .address_error(ae64), .address_error_address(aea64)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [1:0] s, input logic [1:0] m,
                         input logic [31:0] a, input logic [63:0] d);
        wr     = w;
        size   = s;
        mode   = m;
        addr   = a;
        data64 = d;
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [1:0]  mode;
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] maddr;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    logic [63:0] q[$];
    int sent;
    int got;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //          wr    size   mode   addr          data           err   strb     wdata          maddr
        vecs[0]  = '{1'b1, 2'd0, 2'b00, 32'h0000_1003, 32'h0000_00AB, 1'b0, 4'b1000, 32'hABAB_ABAB, 32'h0000_1000};
        vecs[1]  = '{1'b1, 2'd1, 2'b00, 32'h0000_1002, 32'h0000_1234, 1'b0, 4'b1100, 32'h1234_1234, 32'h0000_1000};
        vecs[2]  = '{1'b1, 2'd2, 2'b01, 32'h0000_1001, 32'h1122_3344, 1'b0, 4'b0011, 32'h0000_1122, 32'h0000_1000};
        vecs[3]  = '{1'b1, 2'd2, 2'b10, 32'h0000_1001, 32'h1122_3344, 1'b0, 4'b1110, 32'h2233_4400, 32'h0000_1000};
        vecs[4]  = '{1'b1, 2'd2, 2'b00, 32'h0000_1008, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0000_1008};
        vecs[5]  = '{1'b0, 2'd0, 2'b00, 32'h0000_1001, 32'h0000_0055, 1'b0, 4'b0010, 32'h5555_5555, 32'h0000_1000};
        vecs[6]  = '{1'b1, 2'd2, 2'b00, 32'h0000_1001, 32'h1111_1111, 1'b1, 4'b0000, 32'h0,          32'h0};
        vecs[7]  = '{1'b1, 2'd3, 2'b00, 32'h0000_2000, 32'h2222_2222, 1'b1, 4'b0000, 32'h0,          32'h0};
        vecs[8]  = '{1'b1, 2'd2, 2'b01, 32'h0000_1003, 32'h1122_3344, 1'b0, 4'b1111, 32'h1122_3344, 32'h0000_1000};
        vecs[9]  = '{1'b1, 2'd2, 2'b10, 32'h0000_1003, 32'h1122_3344, 1'b0, 4'b1000, 32'h4400_0000, 32'h0000_1000};
        vecs[10] = '{1'b1, 2'd2, 2'b01, 32'h0000_1000, 32'h1122_3344, 1'b0, 4'b0001, 32'h0000_0011, 32'h0000_1000};
        vecs[11] = '{1'b1, 2'd2, 2'b10, 32'h0000_1000, 32'h1122_3344, 1'b0, 4'b1111, 32'h1122_3344, 32'h0000_1000};
        vecs[12] = '{1'b1, 2'd1, 2'b11, 32'h0000_1002, 32'h0000_BEEF, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0000_1000};
        vecs[13] = '{1'b1, 2'd1, 2'b11, 32'h0000_1003, 32'h0000_BEEF, 1'b1, 4'b0000, 32'h0,          32'h0};

        reset_n = 1'b0;
        v32     = 1'b0;
        v64     = 1'b0;
        flush   = 1'b0;
        mready  = 1'b1;
        drive(1'b0, 2'd0, 2'b00, 32'h0, 64'h0);
        #12;
        chk("rst_occ", 64'(occ32), 64'd0);
        chk("rst_mvalid", 64'(mv32), 64'd0);
        chk("rst_ready", 64'(rdy32), 64'd1);
        chk("rst_err", 64'(ae32), 64'd0);
        chk("rst_err_addr", 64'(aea32), 64'd0);
        chk("rst64_ready", 64'(rdy64), 64'd1);
        chk("rst64_err", 64'({ae64, aea64}), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Single-request vectors through the 32-bit queue with memory always ready.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].wr, vecs[i].size, vecs[i].mode, vecs[i].addr, {32'h0, vecs[i].data});
            v32 = 1'b1;
            @(posedge clock); #1;
            v32 = 1'b0;
            if (vecs[i].err) begin
                chk($sformatf("v%0d_err", i), 64'(ae32), 64'd1);
                chk($sformatf("v%0d_not_queued", i), 64'(mv32), 64'd0);
                chk($sformatf("v%0d_err_addr", i), 64'(aea32), 64'(vecs[i].addr));
            end else begin
                chk($sformatf("v%0d_mvalid", i), 64'(mv32), 64'd1);
                chk($sformatf("v%0d_write", i), 64'(mw32), 64'(vecs[i].wr));
                chk($sformatf("v%0d_strb", i), 64'(ms32), 64'(vecs[i].strb));
                chk($sformatf("v%0d_data", i), 64'(md32), 64'(vecs[i].wdata));
                chk($sformatf("v%0d_addr", i), 64'(ma32), 64'(vecs[i].maddr));
                chk($sformatf("v%0d_no_err", i), 64'(ae32), 64'd0);
            end
            @(posedge clock); #1;
            chk($sformatf("v%0d_err_pulse", i), 64'(ae32), 64'd0);
            chk($sformatf("v%0d_drained", i), 64'(occ32), 64'd0);
        end

        // 64-bit lanes: doubleword and upper-word store.
        drive(1'b1, 2'd3, 2'b00, 32'h0000_2008, 64'h0123_4567_89AB_CDEF);
        v64 = 1'b1;
        @(posedge clock); #1;
        v64 = 1'b0;
        chk("sd64_mvalid", 64'(mv64), 64'd1);
        chk("sd64_write", 64'(mw64), 64'd1);
        chk("sd64_strb", 64'(ms64), 64'hFF);
        chk("sd64_data", md64, 64'h0123_4567_89AB_CDEF);
        chk("sd64_addr", 64'(ma64), 64'h2008);
        @(posedge clock); #1;
        drive(1'b1, 2'd2, 2'b00, 32'h0000_2004, 64'h0000_0000_CAFE_F00D);
        v64 = 1'b1;
        @(posedge clock); #1;
        v64 = 1'b0;
        chk("sw64_strb", 64'(ms64), 64'hF0);
        chk("sw64_data", md64, 64'hCAFE_F00D_CAFE_F00D);
        chk("sw64_addr", 64'(ma64), 64'h2000);
        @(posedge clock); #1;
        chk("sw64_drained", 64'(occ64), 64'd0);

        // Fill to full with memory stalled, then drain in order.
        mready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'd2, 2'b00, 32'h100 + 32'(4 * k), 64'(32'hA0 + k));
            v32 = 1'b1;
            @(posedge clock); #1;
        end
        chk("full_occ", 64'(occ32), 64'd4);
        chk("full_ready", 64'(rdy32), 64'd0);
        drive(1'b1, 2'd2, 2'b00, 32'h200, 64'h99);
        for (int k = 0; k < 2; k++) begin
            @(posedge clock); #1;
            chk("full_blocked_occ", 64'(occ32), 64'd4);
            chk("full_head_hold", 64'(ma32), 64'h100);
        end
        v32    = 1'b0;
        mready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d_valid", k), 64'(mv32), 64'd1);
            chk($sformatf("drain%0d_addr", k), 64'(ma32), 64'(32'h100 + 32'(4 * k)));
            chk($sformatf("drain%0d_data", k), 64'(md32), 64'(32'hA0 + k));
            @(posedge clock); #1;
        end
        chk("drain_empty", 64'(mv32), 64'd0);

        // Ten requests streamed against an intermittent memory_ready, scoreboarded.
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
            v32 = (sent < 10);
            drive(1'b1, 2'd2, 2'b00, 32'h400 + 32'(4 * sent), 64'(32'hC000_0000 + sent));
            mready = (cyc % 3 != 2);
            @(negedge clock);
            chk("wrap_occ", 64'(occ32), 64'(q.size()));
            if (mv32 && mready) begin
                if (q.size() == 0) begin
                    chk("wrap_unexpected_head", 64'(mv32), 64'd0);
                end else begin
                    chk("wrap_head", {ma32, md32}, q[0]);
                    void'(q.pop_front());
                end
                got++;
            end
            if (v32 && rdy32) begin
                q.push_back({addr, data64[31:0]});
                sent++;
            end
            @(posedge clock); #1;
        end
        v32 = 1'b0;
        chk("wrap_complete", 64'(got), 64'd10);
        chk("wrap_empty", 64'(occ32), 64'd0);

        // Flush with 3 queued, head handshake and a new request in the same cycle.
        mready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 2'd2, 2'b00, 32'h500 + 32'(4 * k), 64'(k));
            v32 = 1'b1;
            @(posedge clock); #1;
        end
        chk("pre_flush_occ", 64'(occ32), 64'd3);
        drive(1'b1, 2'd2, 2'b00, 32'h600, 64'h66);
        mready = 1'b1;
        flush  = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        v32   = 1'b0;
        chk("flush_occ", 64'(occ32), 64'd0);
        chk("flush_mvalid", 64'(mv32), 64'd0);
        @(posedge clock); #1;
        chk("flush_dropped", 64'(mv32), 64'd0);

        // Misaligned request during flush raises no error and keeps the old error address.
        drive(1'b1, 2'd2, 2'b00, 32'h3001, 64'h0);
        v32   = 1'b1;
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        v32   = 1'b0;
        chk("flush_err_suppressed", 64'(ae32), 64'd0);
        chk("flush_err_addr_hold", 64'(aea32), 64'h1003);
        chk("flush2_occ", 64'(occ32), 64'd0);

        // Reset asserted mid-burst.
        mready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 2'd2, 2'b00, 32'h700 + 32'(4 * k), 64'(k));
            v32 = 1'b1;
            @(posedge clock); #1;
        end
        v32 = 1'b0;
        chk("pre_reset_occ", 64'(occ32), 64'd2);
        reset_n = 1'b0;
        #1;
        chk("midrst_occ", 64'(occ32), 64'd0);
        chk("midrst_mvalid", 64'(mv32), 64'd0);
        chk("midrst_ready", 64'(rdy32), 64'd1);
        chk("midrst_err_addr", 64'(aea32), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        drive(1'b1, 2'd2, 2'b00, 32'h800, 64'h88);
        v32 = 1'b1;
        @(posedge clock); #1;
        v32 = 1'b0;
        chk("post_rst_accept", 64'(mv32), 64'd1);
        chk("post_rst_addr", 64'(ma32), 64'h800);
        chk("post_rst_occ", 64'(occ32), 64'd1);
        mready = 1'b1;
        @(posedge clock); #1;
        chk("post_rst_drain", 64'(occ32), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
